// File: rtl/i2s_apb_sequencer.sv
// rtl/i2s_apb_sequencer.sv - APB master that configures an I2S transceiver and schedules Tx pushes / Rx pops.
// Optional macro I2S_SEQ_CNT_EN adds saturating tx_count/rx_count outputs.
module i2s_apb_sequencer #(
    parameter logic [31:0] CTRL_ADDR = 32'h0,
    parameter logic [31:0] TXD_ADDR  = 32'h4,
    parameter logic [31:0] RXD_ADDR  = 32'h8,
    parameter logic [31:0] STAT_ADDR = 32'hC,
    parameter int          POLL_GAP  = 4
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ctrl_word,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
`ifdef I2S_SEQ_CNT_EN
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
`endif
    output logic        busy
);
    typedef enum logic [3:0] {
        IDLE, CFG_S, CFG_A, POLL_S, POLL_A, GAP, TX_S, TX_A, RX_S, RX_A
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    state_t      state, state_nx;
    logic [31:0] ctrl_reg;
    logic [31:0] tx_hold;
    logic        last_grant;    // 1 = TX was served last
    logic        stop_pend;
    logic [7:0]  gap_cnt;
    logic        tx_elig, rx_elig;

    // prdata[3:0] = {Tx_full, Tx_empty, Rx_full, Rx_empty}; an Rx pop also needs a free output buffer
    assign tx_elig = tx_valid & ~prdata[3];
    assign rx_elig = ~prdata[0] & ~rx_valid;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = CFG_S;
            CFG_S:  state_nx = CFG_A;
            CFG_A:  state_nx = POLL_S;
            POLL_S: state_nx = POLL_A;
            POLL_A: begin
                if (stop_pend)                state_nx = IDLE;
                else if (tx_elig && rx_elig)  state_nx = last_grant ? RX_S : TX_S;
                else if (tx_elig)             state_nx = TX_S;
                else if (rx_elig)             state_nx = RX_S;
                else if (POLL_GAP == 0)       state_nx = POLL_S;
                else                          state_nx = GAP;
            end
            GAP: begin
                if (stop_pend)                state_nx = IDLE;
                else if (gap_cnt == GAP_LAST) state_nx = POLL_S;
            end
            TX_S:   state_nx = TX_A;
            TX_A:   state_nx = POLL_S;
            RX_S:   state_nx = RX_A;
            RX_A:   state_nx = POLL_S;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 32'h0;
        pwdata   = 32'h0;
        tx_ready = 1'b0;
        busy     = (state != IDLE);
        case (state)
            CFG_S, CFG_A: begin
                psel    = 1'b1;
                penable = (state == CFG_A);
                pwrite  = 1'b1;
                paddr   = CTRL_ADDR;
                pwdata  = ctrl_reg;
            end
            POLL_S, POLL_A: begin
                psel    = 1'b1;
                penable = (state == POLL_A);
                paddr   = STAT_ADDR;
            end
            TX_S, TX_A: begin
                psel     = 1'b1;
                penable  = (state == TX_A);
                pwrite   = 1'b1;
                paddr    = TXD_ADDR;
                pwdata   = tx_hold;
                tx_ready = (state == TX_S);
            end
            RX_S, RX_A: begin
                psel    = 1'b1;
                penable = (state == RX_A);
                paddr   = RXD_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            state      <= IDLE;
            ctrl_reg   <= 32'h0;
            tx_hold    <= 32'h0;
            last_grant <= 1'b0;
            stop_pend  <= 1'b0;
            gap_cnt    <= 8'h0;
            rx_data    <= 32'h0;
            rx_valid   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) ctrl_reg <= ctrl_word;
            // start & stop together in IDLE: start is taken and the stop is kept pending
            if (state == IDLE)  stop_pend <= start & stop;
            else if (stop)      stop_pend <= 1'b1;
            gap_cnt <= (state == GAP) ? gap_cnt + 8'h1 : 8'h0;
            // Data is captured at grant so a late tx_valid drop still writes the granted sample
            if (state == POLL_A && state_nx == TX_S) tx_hold <= tx_data;
            if (state == TX_A) last_grant <= 1'b1;
            if (state == RX_A) begin
                last_grant <= 1'b0;
                rx_data    <= prdata;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_SEQ_CNT_EN
    always_ff @(posedge pclk) begin
        if (!preset || (state == IDLE && start)) begin
            tx_count <= 16'h0;
            rx_count <= 16'h0;
        end else begin
            if (state == TX_A && tx_count != 16'hFFFF) tx_count <= tx_count + 16'h1;
            if (state == RX_A && rx_count != 16'hFFFF) rx_count <= rx_count + 16'h1;
        end
    end
`endif
endmodule

// File: tb/tb_i2s_apb_sequencer.sv
// tb/tb_i2s_apb_sequencer.sv - scoreboard bench for i2s_apb_sequencer.
module tb_i2s_apb_sequencer;
    logic        pclk = 1'b0;
    logic        preset, start, stop;
    logic [31:0] ctrl_word;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        busy;
`ifdef I2S_SEQ_CNT_EN
    logic [15:0] tx_count, rx_count;
`endif

    logic [3:0]  status;
    int          rx_pops;
    int          checks = 0;
    int          errors = 0;
    logic [64:0] apb_q[$];   // {pwrite, paddr, pwdata (0 for reads)}
    logic [31:0] rx_q[$];
    logic [31:0] tx_q[$];
    logic        tx_hs, rx_rd;

    i2s_apb_sequencer dut (
        .pclk(pclk), .preset(preset), .start(start), .stop(stop), .ctrl_word(ctrl_word),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
`ifdef I2S_SEQ_CNT_EN
        .tx_count(tx_count), .rx_count(rx_count),
`endif
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    // Transceiver slave model: status register and an incrementing Rx FIFO
    always_comb begin
        prdata = 32'h0;
        if (paddr == 32'hC)      prdata = {28'h0, status};
        else if (paddr == 32'h8) prdata = 32'hA000_0000 + 32'(rx_pops);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        apb_q.push_back({1'b1, a, d});
    endtask

    task automatic push_r(input logic [31:0] a);
        apb_q.push_back({1'b0, a, 32'h0});
    endtask

    // Advance one cycle; source/slave updates happen #1 after the edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            tx_hs = tx_valid & tx_ready;
            rx_rd = psel & penable & ~pwrite & (paddr == 32'h8);
            @(posedge pclk);
            #1;
            if (tx_hs) begin
                if (tx_q.size() > 0) tx_data = tx_q.pop_front();
                else tx_valid = 1'b0;
            end
            if (rx_rd) rx_pops++;
        end
    endtask

    // Monitor: every APB access phase and every rx handshake is scored against the queues
    always @(negedge pclk) begin
        if (preset) begin
            if (psel && penable) begin
                if (apb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL apb_unexpected: got w=%0d addr %h", pwrite, paddr);
                end else begin
                    logic [64:0] e;
                    e = apb_q.pop_front();
                    check("apb_dir", {31'h0, pwrite}, {31'h0, e[64]});
                    check("apb_addr", paddr, e[63:32]);
                    if (e[64]) check("apb_wdata", pwdata, e[31:0]);
                end
            end
            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %h", rx_data);
                end else begin
                    check("rx_data", rx_data, rx_q.pop_front());
                end
            end
            if (tx_ready) check("tx_valid_held", {31'h0, tx_valid}, 32'h1);
        end
    end

    initial begin
        preset = 1'b0; start = 1'b1; stop = 1'b0; ctrl_word = 32'h0;
        tx_data = 32'h0; tx_valid = 1'b0; rx_ready = 1'b1;
        status = 4'b0101; rx_pops = 0;

        // Reset, with start held high during it
        tick(2);
        check("rst_psel", {31'h0, psel}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rx", {30'h0, rx_valid, tx_ready}, 32'h0);
        check("rst_rxdata", rx_data, 32'h0);
        preset = 1'b1; start = 1'b0;
        tick();
        check("rst_start_ignored", {31'h0, busy}, 32'h0);

        // Config, then a single TX push; stop during TX_S
        ctrl_word = 32'h0000_0A53; tx_data = 32'hDEAD_BEEF; tx_valid = 1'b1;
        push_w(32'h0, 32'h0A53); push_r(32'hC); push_w(32'h4, 32'hDEAD_BEEF); push_r(32'hC);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a_cfg_s", {psel, penable, pwrite, busy}, 4'b1011);
        check("a_cfg_addr", paddr, 32'h0);
        check("a_cfg_data", pwdata, 32'h0A53);
        tick();
        check("a_cfg_a", {psel, penable, pwrite}, 3'b111);
        tick();
        check("a_poll_s", {psel, penable, pwrite}, 3'b100);
        check("a_poll_addr", paddr, 32'hC);
        tick();
        check("a_no_early_ready", {31'h0, tx_ready}, 32'h0);
        tick();
        check("a_tx_ready", {31'h0, tx_ready}, 32'h1);
        check("a_tx_addr", paddr, 32'h4);
        check("a_tx_data", pwdata, 32'hDEAD_BEEF);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("a_tx_a", {tx_ready, penable, busy}, 3'b011);
        tick(3);
        check("a_idle", {psel, busy}, 2'b00);
`ifdef I2S_SEQ_CNT_EN
        check("a_tx_count", {16'h0, tx_count}, 32'h1);
`endif

        // Fresh reset, then both eligible: grants TX, RX, TX
        preset = 1'b0;
        tick(2);
        preset = 1'b1;
        status = 4'b0000; ctrl_word = 32'h5A; tx_data = 32'h1111_0001; tx_valid = 1'b1;
        tx_q.push_back(32'h1111_0002);
        rx_q.push_back(32'hA000_0000);
        push_w(32'h0, 32'h5A); push_r(32'hC); push_w(32'h4, 32'h1111_0001); push_r(32'hC);
        push_r(32'h8); push_r(32'hC); push_w(32'h4, 32'h1111_0002); push_r(32'hC);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(8);
        check("b_rx_s", {psel, penable, pwrite}, 3'b100);
        check("b_rx_addr", paddr, 32'h8);
        tick(4);
        check("b_tx2_data", pwdata, 32'h1111_0002);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(3);
        check("b_idle", {psel, busy}, 2'b00);
`ifdef I2S_SEQ_CNT_EN
        check("b_counts", {tx_count, rx_count}, {16'h2, 16'h1});
`endif

        // Sink stalled: one RX, then output buffer full -> gaps of 4 between polls
        rx_ready = 1'b0; ctrl_word = 32'h77;
        push_w(32'h0, 32'h77); push_r(32'hC); push_r(32'h8); push_r(32'hC); push_r(32'hC);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(8);
        check("c_gap_first", {psel, busy, rx_valid}, 3'b011);
        tick(3);
        check("c_gap_last", {psel, busy}, 2'b01);
        tick();
        check("c_repoll", {psel, penable}, 2'b10);
        check("c_repoll_addr", paddr, 32'hC);
        tick(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("c_idle", {psel, busy, rx_valid}, 3'b001);
        check("c_rx_held", rx_data, 32'hA000_0001);
`ifdef I2S_SEQ_CNT_EN
        check("c_counts", {tx_count, rx_count}, {16'h0, 16'h1});
`endif
        rx_q.push_back(32'hA000_0001);
        rx_ready = 1'b1;
        tick(2);
        check("c_rx_drained", {31'h0, rx_valid}, 32'h0);

        check("apb_q_empty", 32'(apb_q.size()), 32'h0);
        check("rx_q_empty", 32'(rx_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
